uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Consumer stage directly downstream of the UART receive request port. Pulls bytes one at a time from the UART RX FIFO and parses framed host commands: SYNC, OP, LEN, LEN payload bytes, CSUM.
- Presents each validated command to the accelerator command path over a valid/ready interface.
- Returns a one-byte ACK or NAK through the UART transmit request port.

Parameters:
- PKT_SIZE, 8, UART byte width.
- MAX_PAYLOAD, 8, maximum payload bytes per command.
- SYNC_BYTE, 8'hA5, frame start marker.
- ACK_BYTE, 8'h06, response byte for a good frame.
- NAK_BYTE, 8'h15, response byte for a bad frame.
- TIMEOUT_CYCLES, 4096, maximum idle cycles between bytes inside a frame.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- io_rxReq_pkt  in  PKT_SIZE  byte from UART RX; valid while io_rxReq_done=1.
- io_rxReq_ready  in  1  UART RX holds at least one byte.
- io_rxReq_done  in  1  one-cycle pulse, one cycle after io_rxReq_req; byte valid on io_rxReq_pkt.
- io_rxReq_req  out  1  one-cycle byte fetch pulse.
- io_txReq_pkt  out  PKT_SIZE  response byte.
- io_txReq_req  out  1  one-cycle transmit pulse.
- io_txReq_ready  in  1  UART TX can accept a byte.
- io_cmd_valid  out  1  command available.
- io_cmd_ready  in  1  accelerator accepts the command.
- io_cmd_op  out  8  opcode.
- io_cmd_len  out  clog2(MAX_PAYLOAD+1)  payload byte count.
- io_cmd_payload  out  8*MAX_PAYLOAD  payload; byte 0 in bits [7:0]; unused bytes 0.
- io_errCount  out  8  saturating count of frame errors.
- io_busy  out  1  state is not HUNT.

Behaviour:
- Reset (reset=0, asynchronous): state=HUNT. All outputs, payload regs, checksum, timeout counter and io_errCount go to 0.
- Byte fetch:
  - Allowed only in HUNT/OP/LEN/PAYLOAD/CSUM, with io_rxReq_ready=1 and no fetch outstanding.
  - Drives io_rxReq_req=1 for exactly one cycle and sets the outstanding flag.
  - The flag clears on io_rxReq_done. The byte is consumed that cycle.
  - Never more than one outstanding fetch.
  - In ISSUE/RESP no fetches are made, which backpressures into the UART FIFO.
- States and transitions:
  - HUNT: byte==SYNC_BYTE -> OP. Any other byte is discarded silently, no error.
  - OP: store op; csum=op -> LEN.
  - LEN: csum^=len.
    - len>MAX_PAYLOAD -> RESP with NAK, errCount+1.
    - len==0 -> CSUM.
    - otherwise -> PAYLOAD with index 0.
  - PAYLOAD: payload[index]=byte; csum^=byte; index+1. After byte LEN-1 -> CSUM.
  - CSUM:
    - byte==csum -> ISSUE.
    - mismatch -> RESP with NAK, errCount+1. io_cmd_valid is never raised.
  - ISSUE: io_cmd_valid=1 with op/len/payload held stable until the cycle io_cmd_valid&&io_cmd_ready. Next cycle io_cmd_valid=0 -> RESP with ACK.
  - RESP: wait for io_txReq_ready=1. Pulse io_txReq_req for one cycle with io_txReq_pkt=ACK/NAK -> HUNT. io_txReq_pkt holds its value afterwards.
- Payload regs are cleared on entry to OP, so stale bytes never appear.
- Timeout:
  - Counter runs in OP/LEN/PAYLOAD/CSUM and clears on every consumed byte and on state entry.
  - Reaching TIMEOUT_CYCLES-1 -> HUNT, errCount+1, no response byte sent. An outstanding fetch is still honoured; its byte is then parsed in HUNT.
- io_errCount saturates at 8'hFF.
- A byte arriving on the same cycle the timeout fires is discarded; the timeout wins.
- io_busy=1 in all states except HUNT.
- Latency:
  - Final CSUM byte done -> io_cmd_valid: 1 cycle.
  - Accept -> io_txReq_req: at least 1 cycle, then immediate if io_txReq_ready=1.

Test Plan:
- Good frame A5 10 02 12 34 34 -> io_cmd_valid with op=0x10, len=2, payload[15:0]=0x3412, upper bytes 0. With io_cmd_ready=1, exactly one io_txReq_req with pkt=0x06; errCount=0.
- Zero-length frame with garbage first: 00 FF A5 20 00 20 -> garbage ignored; cmd op=0x20, len=0, payload=0; ACK 0x06.
- Bad checksum A5 10 01 55 00 -> io_cmd_valid stays 0; NAK 0x15; errCount=1. A following good frame still parses.
- Oversize length A5 10 09 -> NAK immediately after the LEN byte; errCount=1. Later bytes discarded in HUNT until the next A5.
- Backpressure: io_cmd_ready=0 for 50 cycles with more bytes queued -> no io_rxReq_req during the stall; cmd fields stable. ACK follows acceptance; queued frame then parses.
- Timeout and reset:
  - A5 10 then idle TIMEOUT_CYCLES -> HUNT, errCount+1, no tx.
  - reset=0 mid-PAYLOAD -> all outputs 0 immediately; the next full frame parses correctly.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Framed host command parser: SYNC, OP, LEN, payload, CSUM.
// Pulls bytes from the UART RX port one at a time and hands validated
// commands to the accelerator over valid/ready. Each frame is answered
// with an ACK or NAK byte on the UART TX port.
module uart_cmd_parser #(
  parameter int unsigned PKT_SIZE       = 8,
  parameter int unsigned MAX_PAYLOAD    = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [PKT_SIZE-1:0]                  io_rxReq_pkt,
  input  logic                                 io_rxReq_ready,
  input  logic                                 io_rxReq_done,
  output logic                                 io_rxReq_req,
  output logic [PKT_SIZE-1:0]                  io_txReq_pkt,
  output logic                                 io_txReq_req,
  input  logic                                 io_txReq_ready,
  output logic                                 io_cmd_valid,
  input  logic                                 io_cmd_ready,
  output logic [7:0]                           io_cmd_op,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]     io_cmd_len,
  output logic [8*MAX_PAYLOAD-1:0]             io_cmd_payload,
  output logic [7:0]                           io_errCount,
  output logic                                 io_busy
);
  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_OP, S_LEN, S_PAY, S_CSUM, S_ISSUE, S_RESP
  } state_t;

  state_t                              state_q, state_d;
  logic                                out_q, out_d;   // fetch outstanding
  logic                                req_q, req_d;
  logic [7:0]                          op_q, op_d;
  logic [LW-1:0]                       len_q, len_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic [7:0]                          csum_q, csum_d;
  logic [MAX_PAYLOAD-1:0][7:0]         pay_q, pay_d;
  logic [TW-1:0]                       tmo_q, tmo_d;
  logic [7:0]                          err_q, err_d;
  logic [PKT_SIZE-1:0]                 txp_q, txp_d;

  logic [7:0] rx_byte;
  logic       rx_v, timed, tmo_fire, fetch_ok, err_inc;

  assign rx_byte  = io_rxReq_pkt[7:0];
  assign rx_v     = io_rxReq_done && out_q;
  assign timed    = state_q inside {S_OP, S_LEN, S_PAY, S_CSUM};
  assign tmo_fire = timed && (tmo_q == TMO_MAX);
  // Fetching stops in ISSUE/RESP so the UART FIFO absorbs the backlog.
  assign fetch_ok = (state_q inside {S_HUNT, S_OP, S_LEN, S_PAY, S_CSUM})
                    && io_rxReq_ready && !out_q;

  assign io_rxReq_req   = req_q;
  assign io_txReq_pkt   = txp_q;
  assign io_txReq_req   = (state_q == S_RESP) && io_txReq_ready;
  assign io_cmd_valid   = (state_q == S_ISSUE);
  assign io_cmd_op      = op_q;
  assign io_cmd_len     = len_q;
  assign io_cmd_payload = pay_q;
  assign io_errCount    = err_q;
  assign io_busy        = (state_q != S_HUNT);

  // Next-state, frame parsing, checksum and timeout bookkeeping.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    pay_d   = pay_q;
    txp_d   = txp_q;
    err_inc = 1'b0;
    req_d   = fetch_ok;
    out_d   = fetch_ok ? 1'b1 : (io_rxReq_done ? 1'b0 : out_q);

    if (tmo_fire) begin
      // Timeout beats any byte landing this cycle; no response is sent.
      state_d = S_HUNT;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        S_HUNT: if (rx_v && rx_byte == SYNC_BYTE) begin
          state_d = S_OP;
          pay_d   = '0;
        end
        S_OP: if (rx_v) begin
          op_d    = rx_byte;
          csum_d  = rx_byte;
          state_d = S_LEN;
        end
        S_LEN: if (rx_v) begin
          csum_d = csum_q ^ rx_byte;
          if (rx_byte > 8'(MAX_PAYLOAD)) begin
            txp_d   = PKT_SIZE'(NAK_BYTE);
            err_inc = 1'b1;
            state_d = S_RESP;
          end else if (rx_byte == 8'd0) begin
            len_d   = '0;
            state_d = S_CSUM;
          end else begin
            len_d   = rx_byte[LW-1:0];
            idx_d   = '0;
            state_d = S_PAY;
          end
        end
        S_PAY: if (rx_v) begin
          pay_d[idx_q] = rx_byte;
          csum_d       = csum_q ^ rx_byte;
          idx_d        = idx_q + IW'(1);
          if (LW'(idx_q) + LW'(1) == len_q) state_d = S_CSUM;
        end
        S_CSUM: if (rx_v) begin
          if (rx_byte == csum_q) begin
            state_d = S_ISSUE;
          end else begin
            txp_d   = PKT_SIZE'(NAK_BYTE);
            err_inc = 1'b1;
            state_d = S_RESP;
          end
        end
        S_ISSUE: if (io_cmd_ready) begin
          txp_d   = PKT_SIZE'(ACK_BYTE);
          state_d = S_RESP;
        end
        S_RESP: if (io_txReq_ready) state_d = S_HUNT;
        default: state_d = S_HUNT;
      endcase
    end

    // Idle counter restarts on every consumed byte and every state entry.
    if (!timed || rx_v || state_d != state_q) tmo_d = '0;
    else                                       tmo_d = tmo_q + TW'(1);

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_HUNT;
      out_q   <= 1'b0;
      req_q   <= 1'b0;
      op_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      pay_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      txp_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      req_q   <= req_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      pay_q   <= pay_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      txp_q   <= txp_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a small UART RX/TX model.
module tb_uart_cmd_parser;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  io_rxReq_pkt = '0;
  logic        io_rxReq_ready = 1'b0;
  logic        io_rxReq_done = 1'b0;
  logic        io_rxReq_req;
  logic [7:0]  io_txReq_pkt;
  logic        io_txReq_req;
  logic        io_txReq_ready = 1'b0;
  logic        io_cmd_valid;
  logic        io_cmd_ready = 1'b0;
  logic [7:0]  io_cmd_op;
  logic [3:0]  io_cmd_len;
  logic [63:0] io_cmd_payload;
  logic [7:0]  io_errCount;
  logic        io_busy;

  uart_cmd_parser dut (
    .clock(clock), .reset(reset),
    .io_rxReq_pkt(io_rxReq_pkt), .io_rxReq_ready(io_rxReq_ready),
    .io_rxReq_done(io_rxReq_done), .io_rxReq_req(io_rxReq_req),
    .io_txReq_pkt(io_txReq_pkt), .io_txReq_req(io_txReq_req),
    .io_txReq_ready(io_txReq_ready),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_op(io_cmd_op), .io_cmd_len(io_cmd_len),
    .io_cmd_payload(io_cmd_payload),
    .io_errCount(io_errCount), .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // UART RX FIFO model: byte appears with done one cycle after req.
  logic [7:0] rxq[$];
  logic       pend = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      io_rxReq_done = 1'b0;
      pend = 1'b0;
    end else begin
      io_rxReq_done = 1'b0;
      if (pend) begin
        io_rxReq_done = 1'b1;
        io_rxReq_pkt  = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
        pend = 1'b0;
      end
      if (io_rxReq_req) pend = 1'b1;
    end
    io_rxReq_ready = (rxq.size() != 0);
  end

  // Monitors: fetch/tx/cmd counts and the captured command fields.
  int          rx_cnt = 0, tx_cnt = 0, cmd_cnt = 0, rx_at_tx = 0;
  logic [7:0]  tx_last = '0, c_op = '0;
  logic [3:0]  c_len = '0;
  logic [63:0] c_pay = '0;
  always @(negedge clock) begin
    if (io_rxReq_req) rx_cnt++;
    if (io_txReq_req) begin
      tx_cnt++;
      tx_last  = io_txReq_pkt;
      rx_at_tx = rx_cnt;
    end
    if (io_cmd_valid && io_cmd_ready) begin
      cmd_cnt++;
      c_op  = io_cmd_op;
      c_len = io_cmd_len;
      c_pay = io_cmd_payload;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic wait_tx(input int target, input string tag);
    int n = 0;
    while (tx_cnt < target && n < 3000) begin tick(); n++; end
    chk(tag, 64'(tx_cnt), 64'(target));
    tick(2);
  endtask

  int rx0, tx0, cmd0, viol;
  logic [7:0]  s_op;
  logic [63:0] s_pay;

  initial begin
    // Reset state
    tick(3);
    chk("rst_rxreq", io_rxReq_req, 0);
    chk("rst_txreq", io_txReq_req, 0);
    chk("rst_valid", io_cmd_valid, 0);
    chk("rst_err",   io_errCount, 0);
    chk("rst_busy",  io_busy, 0);
    chk("rst_pay",   io_cmd_payload, 0);
    reset = 1'b1;
    io_cmd_ready = 1'b1;
    io_txReq_ready = 1'b1;
    tick(2);

    // Good frame
    push(8'hA5); push(8'h10); push(8'h02); push(8'h12); push(8'h34); push(8'h34);
    wait_tx(1, "a_tx_cnt");
    chk("a_cmd_cnt", cmd_cnt, 1);
    chk("a_op", c_op, 8'h10);
    chk("a_len", c_len, 2);
    chk("a_pay", c_pay, 64'h3412);
    chk("a_ack", tx_last, 8'h06);
    chk("a_err", io_errCount, 0);
    chk("a_busy", io_busy, 0);

    // Garbage then zero-length frame
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h20); push(8'h00); push(8'h20);
    wait_tx(2, "b_tx_cnt");
    chk("b_cmd_cnt", cmd_cnt, 2);
    chk("b_op", c_op, 8'h20);
    chk("b_len", c_len, 0);
    chk("b_pay", c_pay, 64'h0);
    chk("b_ack", tx_last, 8'h06);
    chk("b_err", io_errCount, 0);

    // Bad checksum, then a good frame
    push(8'hA5); push(8'h10); push(8'h01); push(8'h55); push(8'h00);
    wait_tx(3, "c_tx_cnt");
    chk("c_cmd_cnt", cmd_cnt, 2);
    chk("c_nak", tx_last, 8'h15);
    chk("c_err", io_errCount, 1);
    push(8'hA5); push(8'h10); push(8'h02); push(8'h12); push(8'h34); push(8'h34);
    wait_tx(4, "c2_tx_cnt");
    chk("c2_cmd_cnt", cmd_cnt, 3);
    chk("c2_pay", c_pay, 64'h3412);
    chk("c2_ack", tx_last, 8'h06);

    // Oversize length: NAK right after LEN, trailing bytes dropped in HUNT
    rx0 = rx_cnt;
    push(8'hA5); push(8'h10); push(8'h09); push(8'h01); push(8'h02);
    wait_tx(5, "d_tx_cnt");
    chk("d_nak", tx_last, 8'h15);
    chk("d_nak_after_len", 64'(rx_at_tx - rx0), 3);
    chk("d_err", io_errCount, 2);
    push(8'hA5); push(8'h30); push(8'h01); push(8'h77); push(8'h46);
    wait_tx(6, "d2_tx_cnt");
    chk("d2_cmd_cnt", cmd_cnt, 4);
    chk("d2_op", c_op, 8'h30);
    chk("d2_pay", c_pay, 64'h77);
    chk("d2_err", io_errCount, 2);

    // Backpressure on the command port with a second frame queued
    io_cmd_ready = 1'b0;
    push(8'hA5); push(8'h40); push(8'h01); push(8'hAA); push(8'hEB);
    push(8'hA5); push(8'h50); push(8'h00); push(8'h50);
    begin
      int n = 0;
      while (!io_cmd_valid && n < 200) begin tick(); n++; end
    end
    chk("e_valid", io_cmd_valid, 1);
    rx0 = rx_cnt; tx0 = tx_cnt; cmd0 = cmd_cnt;
    s_op = io_cmd_op; s_pay = io_cmd_payload;
    viol = 0;
    repeat (50) begin
      tick();
      if (io_rxReq_req || io_cmd_op !== s_op || io_cmd_payload !== s_pay || !io_cmd_valid)
        viol++;
    end
    chk("e_stall_stable", viol, 0);
    chk("e_stall_rx", 64'(rx_cnt), 64'(rx0));
    chk("e_stall_tx", 64'(tx_cnt), 64'(tx0));
    chk("e_op", s_op, 8'h40);
    chk("e_pay", s_pay, 64'hAA);
    io_cmd_ready = 1'b1;
    wait_tx(tx0 + 1, "e_tx_cnt");
    chk("e_ack", tx_last, 8'h06);
    wait_tx(tx0 + 2, "e2_tx_cnt");
    chk("e2_cmd_cnt", 64'(cmd_cnt), 64'(cmd0 + 2));
    chk("e2_op", c_op, 8'h50);
    chk("e2_len", c_len, 0);

    // Timeout after SYNC OP with nothing else
    tx0 = tx_cnt;
    push(8'hA5); push(8'h10);
    tick(100);
    chk("f_busy_early", io_busy, 1);
    tick(3900);
    chk("f_busy_before_tmo", io_busy, 1);
    tick(300);
    chk("f_busy_after_tmo", io_busy, 0);
    chk("f_err", io_errCount, 3);
    chk("f_no_tx", 64'(tx_cnt), 64'(tx0));

    // Asynchronous reset in the middle of a payload
    push(8'hA5); push(8'h60); push(8'h04); push(8'h01); push(8'h02);
    tick(40);
    chk("g_busy_mid", io_busy, 1);
    reset = 1'b0;
    #1;
    chk("g_rst_busy", io_busy, 0);
    chk("g_rst_err", io_errCount, 0);
    chk("g_rst_op", io_cmd_op, 0);
    chk("g_rst_pay", io_cmd_payload, 0);
    chk("g_rst_txpkt", io_txReq_pkt, 0);
    chk("g_rst_rxreq", io_rxReq_req, 0);
    rxq.delete();
    tick(3);
    reset = 1'b1;
    tick(2);
    tx0 = tx_cnt;
    push(8'hA5); push(8'h70); push(8'h02); push(8'hAB); push(8'hCD); push(8'h14);
    wait_tx(tx0 + 1, "g_tx_cnt");
    chk("g_op", c_op, 8'h70);
    chk("g_len", c_len, 2);
    chk("g_pay", c_pay, 64'hCDAB);
    chk("g_ack", tx_last, 8'h06);
    chk("g_err", io_errCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
